// File: rtl/cpack_pkg.sv
// rtl/cpack_pkg.sv - prefix-code definitions shared by the cpack compressor and decoder
package cpack_pkg;

  localparam int DICT_IDX_W = 4;

  typedef enum logic [2:0] {
    ZZZZ,
    XXXX,
    MMMM,
    MMXX,
    ZZZX,
    MMMX,
    ILLEGAL
  } code_t;

  localparam logic [5:0] LEN_ZZZZ = 6'd2;
  localparam logic [5:0] LEN_XXXX = 6'd34;
  localparam logic [5:0] LEN_MMMM = 6'd6;
  localparam logic [5:0] LEN_MMXX = 6'd24;
  localparam logic [5:0] LEN_ZZZX = 6'd12;
  localparam logic [5:0] LEN_MMMX = 6'd16;

  localparam logic [1:0] PFX_ZZZZ    = 2'b00;
  localparam logic [1:0] PFX_XXXX    = 2'b01;
  localparam logic [1:0] PFX_MMMM    = 2'b10;
  localparam logic [1:0] PFX_LONG    = 2'b11;
  localparam logic [3:0] PFX_MMXX    = 4'b1100;
  localparam logic [3:0] PFX_ZZZX    = 4'b1101;
  localparam logic [3:0] PFX_MMMX    = 4'b1110;
  localparam logic [3:0] PFX_ILLEGAL = 4'b1111;

  // Only the top four stream bits are needed to identify any code.
  function automatic code_t classify(input logic [3:0] hdr);
    code_t c;
    case (hdr[3:2])
      PFX_ZZZZ: c = ZZZZ;
      PFX_XXXX: c = XXXX;
      PFX_MMMM: c = MMMM;
      default: begin
        case (hdr)
          PFX_MMXX: c = MMXX;
          PFX_ZZZX: c = ZZZX;
          PFX_MMMX: c = MMMX;
          default:  c = ILLEGAL;
        endcase
      end
    endcase
    return c;
  endfunction

  function automatic logic [5:0] code_len(input code_t c);
    logic [5:0] l;
    case (c)
      ZZZZ:    l = LEN_ZZZZ;
      XXXX:    l = LEN_XXXX;
      MMMM:    l = LEN_MMMM;
      MMXX:    l = LEN_MMXX;
      ZZZX:    l = LEN_ZZZX;
      MMMX:    l = LEN_MMMX;
      default: l = 6'd4;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/cpack_fifo_dict.sv
// rtl/cpack_fifo_dict.sv - FIFO-replacement dictionary with combinational read and flat image
module cpack_fifo_dict
  import cpack_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic [DICT_IDX_W-1:0]       rd_idx,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic [DICT_IDX_W-1:0]       wr_ptr,
  output logic [DEPTH*DATA_WIDTH-1:0] dict_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= (wr_ptr == DICT_IDX_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    end
  end

  assign rd_data = mem[rd_idx];

  for (genvar g = 0; g < DEPTH; g++) begin : g_image
    assign dict_data[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
  end

endmodule

// File: rtl/cpack_stream_decoder.sv
// rtl/cpack_stream_decoder.sv - parses the packed MSB-first prefix-code stream into 32-bit words
module cpack_stream_decoder
  import cpack_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int CHUNK_WIDTH    = 32,
  parameter int DICT_ENTRY     = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int BUF_WIDTH      = 64
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [CHUNK_WIDTH-1:0]           i_chunk,
  input  logic                             i_chunk_valid,
  output logic                             o_chunk_ready,
  output logic [DATA_WIDTH-1:0]            o_word,
  output logic                             o_word_valid,
  output logic                             o_word_last,
  input  logic                             i_word_ready,
  output logic                             o_error,
  output logic [DICT_ENTRY*DATA_WIDTH-1:0] o_dict_data
);

  localparam int FILL_W = $clog2(BUF_WIDTH + 1);
  localparam int CNT_W  = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int B      = BUF_WIDTH;

  typedef enum logic {RUN, ERR} state_t;

  state_t                state_q, state_d;
  logic [B-1:0]          buf_q, buf_d, shifted;
  logic [FILL_W-1:0]     fill_q, fill_d, fill_c;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_d;
  logic                  valid_d, last_d;

  logic [3:0]            hdr;
  code_t                 code;
  logic [5:0]            len;
  logic                  run, hdr_ok, fire, line_end, accept;
  logic [DICT_IDX_W-1:0] rd_idx, wr_ptr;
  logic [DATA_WIDTH-1:0] rd_data, decoded;

  // Field positions are fixed relative to the left-aligned head of the buffer.
  logic [DATA_WIDTH-1:0] f_w;
  logic [DICT_IDX_W-1:0] f_idx_short, f_idx_long;
  logic [15:0]           f_d16;
  logic [7:0]            f_b8_short, f_b8_long;

  assign hdr         = buf_q[B-1 -: 4];
  assign code        = classify(hdr);
  assign len         = code_len(code);
  assign f_w         = buf_q[B-3 -: DATA_WIDTH];
  assign f_idx_short = buf_q[B-3 -: DICT_IDX_W];
  assign f_idx_long  = buf_q[B-5 -: DICT_IDX_W];
  assign f_d16       = buf_q[B-9 -: 16];
  assign f_b8_short  = buf_q[B-5 -: 8];
  assign f_b8_long   = buf_q[B-9 -: 8];

  assign run      = (state_q == RUN);
  assign hdr_ok   = (fill_q >= FILL_W'(2)) &&
                    ((hdr[3:2] != PFX_LONG) || (fill_q >= FILL_W'(4)));
  assign fire     = run && hdr_ok && (code != ILLEGAL) &&
                    (fill_q >= FILL_W'(len)) && (!o_word_valid || i_word_ready);
  assign line_end = fire && (cnt_q == CNT_W'(WORDS_PER_LINE - 1));

  assign o_chunk_ready = i_reset && run && (fill_q <= FILL_W'(BUF_WIDTH - CHUNK_WIDTH));
  assign accept        = i_chunk_valid && o_chunk_ready;
  assign o_error       = (state_q == ERR);

  assign rd_idx = (code == MMMM) ? f_idx_short : f_idx_long;

  cpack_fifo_dict #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DICT_ENTRY)
  ) u_dict (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .wr_en     (fire && (code == XXXX)),
    .wr_data   (f_w),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .wr_ptr    (wr_ptr),
    .dict_data (o_dict_data)
  );

  always_comb begin
    decoded = '0;
    case (code)
      XXXX:    decoded = f_w;
      MMMM:    decoded = rd_data;
      MMXX:    decoded = {rd_data[DATA_WIDTH-1 -: DATA_WIDTH-16], f_d16};
      ZZZX:    decoded = {{(DATA_WIDTH-8){1'b0}}, f_b8_short};
      MMMX:    decoded = {rd_data[DATA_WIDTH-1 -: DATA_WIDTH-8], f_b8_long};
      default: decoded = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    shifted = buf_q;
    fill_c  = fill_q;
    cnt_d   = cnt_q;
    word_d  = o_word;
    valid_d = o_word_valid;
    last_d  = o_word_last;

    if (run && hdr_ok && (code == ILLEGAL)) state_d = ERR;

    // Lines are chunk-padded, so whatever remains after the last word is padding.
    if (line_end) begin
      shifted = '0;
      fill_c  = '0;
      cnt_d   = '0;
    end else if (fire) begin
      shifted = buf_q << len;
      fill_c  = fill_q - FILL_W'(len);
      cnt_d   = cnt_q + 1'b1;
    end

    buf_d  = shifted;
    fill_d = fill_c;
    if (accept) begin
      buf_d  = shifted | ({i_chunk, {(B-CHUNK_WIDTH){1'b0}}} >> fill_c);
      fill_d = fill_c + FILL_W'(CHUNK_WIDTH);
    end

    if (fire) begin
      word_d  = decoded;
      valid_d = 1'b1;
      last_d  = line_end;
    end else if (i_word_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= RUN;
      buf_q        <= '0;
      fill_q       <= '0;
      cnt_q        <= '0;
      o_word       <= '0;
      o_word_valid <= 1'b0;
      o_word_last  <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      fill_q       <= fill_d;
      cnt_q        <= cnt_d;
      o_word       <= word_d;
      o_word_valid <= valid_d;
      o_word_last  <= last_d;
    end
  end

endmodule

// File: tb/tb_cpack_stream_decoder.sv
// tb/tb_cpack_stream_decoder.sv - scoreboard bench for cpack_stream_decoder
module tb_cpack_stream_decoder;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic [31:0]  i_chunk;
  logic         i_chunk_valid;
  logic         o_chunk_ready;
  logic [31:0]  o_word;
  logic         o_word_valid;
  logic         o_word_last;
  logic         i_word_ready;
  logic         o_error;
  logic [511:0] o_dict_data;

  always #5 i_clk = ~i_clk;

  cpack_stream_decoder dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_chunk       (i_chunk),
    .i_chunk_valid (i_chunk_valid),
    .o_chunk_ready (o_chunk_ready),
    .o_word        (o_word),
    .o_word_valid  (o_word_valid),
    .o_word_last   (o_word_last),
    .i_word_ready  (i_word_ready),
    .o_error       (o_error),
    .o_dict_data   (o_dict_data)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  bit          bits_q[$];
  logic [31:0] chunk_q[$];
  logic [32:0] exp_q[$];
  int          out_cyc[$];
  logic [31:0] mdict[16];
  int          mptr;
  int          line_cnt;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_bits(input logic [33:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bits_q.push_back(v[i]);
  endtask

  task automatic flush_line();
    logic [31:0] c;
    while (bits_q.size() % 32 != 0) bits_q.push_back(1'b0);
    while (bits_q.size() > 0) begin
      for (int i = 31; i >= 0; i--) c[i] = bits_q.pop_front();
      chunk_q.push_back(c);
    end
  endtask

  task automatic emit(input logic [31:0] w);
    line_cnt++;
    exp_q.push_back({(line_cnt == 4), w});
    if (line_cnt == 4) begin
      line_cnt = 0;
      flush_line();
    end
  endtask

  task automatic enc_zzzz();
    push_bits(34'd0, 2);
    emit(32'd0);
  endtask

  task automatic enc_xxxx(input logic [31:0] w);
    push_bits({2'b01, w}, 34);
    mdict[mptr] = w;
    mptr = (mptr + 1) % 16;
    emit(w);
  endtask

  task automatic enc_mmmm(input logic [3:0] idx);
    push_bits({28'd0, 2'b10, idx}, 6);
    emit(mdict[idx]);
  endtask

  task automatic enc_mmxx(input logic [3:0] idx, input logic [15:0] d);
    logic [31:0] e;
    e = mdict[idx];
    push_bits({10'd0, 4'b1100, idx, d}, 24);
    emit({e[31:16], d});
  endtask

  task automatic enc_zzzx(input logic [7:0] b);
    push_bits({22'd0, 4'b1101, b}, 12);
    emit({24'd0, b});
  endtask

  task automatic enc_mmmx(input logic [3:0] idx, input logic [7:0] b);
    logic [31:0] e;
    e = mdict[idx];
    push_bits({18'd0, 4'b1110, idx, b}, 16);
    emit({e[31:8], b});
  endtask

  task automatic check_dict(input string tag);
    @(negedge i_clk);
    for (int i = 0; i < 16; i++) chk(tag, o_dict_data[i*32 +: 32], mdict[i]);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge i_clk);
      n++;
    end
    repeat (2) @(posedge i_clk);
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    bits_q.delete();
    chunk_q.delete();
    exp_q.delete();
    line_cnt = 0;
    mptr = 0;
    for (int i = 0; i < 16; i++) mdict[i] = 32'd0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", o_word_valid, 0);
    chk("rst_last", o_word_last, 0);
    chk("rst_word", o_word, 0);
    chk("rst_error", o_error, 0);
    chk("rst_cready", o_chunk_ready, 0);
    chk("rst_dict", o_dict_data[511:448] | o_dict_data[63:0], 0);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("post_rst_cready", o_chunk_ready, 1);
    chk("post_rst_error", o_error, 0);
  endtask

  // Chunk driver: presents the queue head; pops it on an accepted handshake.
  initial begin
    logic acc;
    i_chunk = '0;
    i_chunk_valid = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_reset === 1'b1 && chunk_q.size() > 0) begin
        i_chunk = chunk_q[0];
        i_chunk_valid = 1'b1;
      end else begin
        i_chunk_valid = 1'b0;
      end
      acc = i_chunk_valid && o_chunk_ready;
      @(posedge i_clk);
      if (acc && chunk_q.size() > 0) void'(chunk_q.pop_front());
    end
  end

  // Output monitor: every transferred word is matched against the scoreboard.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge i_clk);
      if (i_reset === 1'b1 && o_word_valid && i_word_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", {32'd0, o_word}, 64'h1_0000_0000);
        end else begin
          e = exp_q.pop_front();
          chk("word", o_word, e[31:0]);
          chk("last", o_word_last, e[32]);
          out_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    logic        saw_low;
    logic [3:0]  pre;
    int          n;

    i_reset = 1'b0;
    i_word_ready = 1'b1;
    do_reset();
    check_dict("dict_rst");

    // Line A
    enc_xxxx(32'hAABBCCDD);
    enc_mmmm(4'd0);
    enc_zzzz();
    enc_zzzx(8'h12);
    wait_drain(200);
    check_dict("dict_a");
    chk("dict_a0", o_dict_data[31:0], 32'hAABBCCDD);
    chk("dict_a1", o_dict_data[63:32], 32'd0);

    // Line B reuses entry 0 from line A
    enc_mmmx(4'd0, 8'h99);
    enc_mmxx(4'd0, 16'h1234);
    enc_mmmm(4'd0);
    enc_zzzz();
    wait_drain(200);
    check_dict("dict_b");

    // Backpressure mid-line
    @(posedge i_clk);
    #1 i_word_ready = 1'b0;
    for (int i = 0; i < 4; i++) enc_xxxx(32'hA0 + i);
    n = 0;
    while (!o_word_valid && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk("bp_valid", o_word_valid, 1);
    held = o_word;
    saw_low = 1'b0;
    repeat (6) begin
      @(negedge i_clk);
      chk("bp_hold", o_word, held);
      if (!o_chunk_ready) saw_low = 1'b1;
    end
    chk("bp_cready_drop", saw_low, 1);
    chk("bp_pending", exp_q.size(), 4);
    @(posedge i_clk);
    #1 i_word_ready = 1'b1;
    wait_drain(300);
    check_dict("dict_bp");

    // Seventeen literals wrap the write pointer
    do_reset();
    for (int i = 0; i < 17; i++) enc_xxxx(32'h100 + i);
    enc_mmmm(4'd0);
    enc_zzzz();
    enc_zzzz();
    wait_drain(1000);
    chk("wrap_dict0", o_dict_data[31:0], 32'h110);
    chk("wrap_dict1", o_dict_data[63:32], 32'h101);
    check_dict("dict_wrap");

    // Literal immediately referenced by the next code
    pre = mptr[3:0];
    out_cyc.delete();
    enc_xxxx(32'hDEADBEEF);
    enc_mmmm(pre);
    enc_zzzz();
    enc_zzzz();
    wait_drain(300);
    chk("b2b_count", out_cyc.size(), 4);
    chk("b2b_gap", (out_cyc.size() >= 2) ? out_cyc[1] - out_cyc[0] : 0, 1);
    chk("b2b_dict1", o_dict_data[63:32], 32'hDEADBEEF);

    // Illegal prefix
    push_bits({2'b01, 32'h55}, 34);
    exp_q.push_back({1'b0, 32'h55});
    push_bits(34'hF, 4);
    flush_line();
    n = 0;
    while (!o_error && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    chk("err_set", o_error, 1);
    repeat (10) begin
      @(negedge i_clk);
      chk("err_sticky", o_error, 1);
    end
    chk("err_novalid", o_word_valid, 0);
    chk("err_cready", o_chunk_ready, 0);
    chk("err_drained", exp_q.size(), 0);

    do_reset();
    check_dict("dict_err_rst");

    // Abort a line partway through, then decode a clean line
    enc_xxxx(32'hCAFEF00D);
    enc_zzzz();
    flush_line();
    repeat (4) @(posedge i_clk);
    do_reset();
    check_dict("dict_abort");
    enc_xxxx(32'h12345678);
    enc_mmmm(4'd0);
    enc_zzzx(8'h34);
    enc_mmmx(4'd0, 8'hEE);
    wait_drain(200);
    check_dict("dict_clean");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
